instruction_encode: RTL and testbench
=====================================

INSTRUCTION_ENCODE -- requirements
Module: instruction_encode

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port reset.
REQ-002 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-003 Port reset: input, 1 bit, synchronous active-high reset.
REQ-004 Port in_valid: input, 1 bit, field bundle present.
REQ-005 Port in_ready: output, 1 bit, bundle accepted when in_valid && in_ready at a clk edge.
REQ-006 Ports is_r_instr, is_i_instr, is_s_instr, is_b_instr, is_u_instr, is_j_instr: inputs, 1 bit each, instruction format select.
REQ-007 Ports opcode [6:0], rd [4:0], funct3 [2:0], rs1 [4:0], rs2 [4:0], funct7 [6:0], imm [31:0]: inputs, instruction fields; imm is the byte-offset/immediate value.
REQ-008 Port out_valid: output, 1 bit, instr valid.
REQ-009 Port out_ready: input, 1 bit, word consumed when out_valid && out_ready at a clk edge.
REQ-010 Port instr: output, 32 bits, encoded RV32I word.
REQ-011 Port err: output, 1 bit, qualifies instr as illegal bundle.
REQ-012 Port err_count: output, 8 bits, saturating count of err words handed off.

Function
REQ-013 The block SHALL be a two-stage pipeline: S1 registers fields and computes err; S2 registers assembled instr/err.
REQ-014 Latency SHALL be 2 cycles from input handshake to out_valid, with out_ready high; throughput one word per cycle.
REQ-015 S2 SHALL load when S2 is empty or out_ready=1; S1 SHALL load when S1 is empty or S1 moves to S2.
REQ-016 in_ready SHALL equal !(s1_valid && s2_valid && !out_ready), combinational from state and out_ready.
REQ-017 While out_valid=1 and out_ready=0, instr and err SHALL hold stable; no bundle lost, duplicated or reordered.
REQ-018 Formats SHALL be: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-019 Further formats SHALL be: B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-020 err SHALL be 1 when the is_* inputs are not exactly one-hot, or opcode[1:0] != 2'b11.
REQ-021 When err=1, instr SHALL be 32'h0000_0013 (NOP).
REQ-022 err_count SHALL increment on each output handshake with err=1, and saturate at 8'hFF.

Reset
REQ-023 With reset=1 at a clk edge, S1/S2 valid SHALL clear, so out_valid=0, instr=0, err=0 and err_count=0.
REQ-024 Bundles in flight at reset SHALL be discarded; in_ready SHALL be 1 in the cycle after reset.
REQ-025 in_valid during reset cycles SHALL be ignored.

Configuration
REQ-026 Macro ENC_IMM_CHECK_EN defined: err SHALL also be set for a non-encodable imm.
- I/S: imm not the sign-extension of imm[11:0].
- B: imm not the sign-extension of imm[12:0], or imm[0]=1.
- J: imm not the sign-extension of imm[20:0], or imm[0]=1.
- U: imm[11:0] != 0.
REQ-027 Macro ENC_IMM_CHECK_EN undefined: no imm check SHALL be made, and unused imm bits SHALL be silently dropped.

Verification
REQ-028 ADDI x1,x0,21 (I, opcode 0x13, imm 21) -> instr 0x01500093, err 0, out_valid exactly 2 cycles after accept.
REQ-029 Back-to-back ADD x3,x1,x2 (R, 0x33), SW x2,1(x1) (S, 0x23, funct3 2), JAL x25,4 (J, 0x6F) -> 0x002081B3, 0x0020A0A3, 0x00400CEF on consecutive cycles.
REQ-030 Stall: 4 back-to-back bundles with out_ready=0 for 3 cycles.
- in_ready drops after 2 bundles are accepted.
- instr holds stable during the stall.
- All 4 words emerge in order once out_ready=1.
REQ-031 Errors: is_i_instr=is_r_instr=1, then opcode 0x10.
- Each -> err 1, instr 0x00000013.
- err_count steps 0->1->2.
REQ-032 ENC_IMM_CHECK_EN defined: I imm 0x800 -> err 1; B imm 3 -> err 1. Undefined: the same I bundle -> err 0, instr[31:20]=0x800.
REQ-033 Reset asserted with both stages full and err_count=5 -> next cycle out_valid 0, err_count 0, in_ready 1.

Source files
------------

// File: rtl/instruction_encode.sv
// instruction_encode: two-stage RV32I instruction word encoder.
// S1 registers the incoming field bundle; its combinational tail assembles the
// word for the selected format and decides whether the bundle is illegal.
// S2 registers the assembled word and error flag and presents them downstream.
// Optional feature: define ENC_IMM_CHECK_EN to also flag immediates that the
// selected format cannot represent (otherwise unused imm bits are dropped).
`timescale 1ns/1ps

module instruction_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_r_instr,
    input  logic        is_i_instr,
    input  logic        is_s_instr,
    input  logic        is_b_instr,
    input  logic        is_u_instr,
    input  logic        is_j_instr,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int NUM_FMT = 6;
    localparam int FMT_R   = 0;
    localparam int FMT_I   = 1;
    localparam int FMT_S   = 2;
    localparam int FMT_B   = 3;
    localparam int FMT_U   = 4;
    localparam int FMT_J   = 5;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Format selects gathered into one vector, indexed by the FMT_* constants.
    logic [NUM_FMT-1:0] sel_in;
    assign sel_in = {is_j_instr, is_u_instr, is_b_instr, is_s_instr, is_i_instr, is_r_instr};

    // Stage 1 state.
    logic               s1_valid_reg;
    logic [NUM_FMT-1:0] s1_sel_reg;
    logic [6:0]         s1_opcode_reg;
    logic [4:0]         s1_rd_reg;
    logic [2:0]         s1_funct3_reg;
    logic [4:0]         s1_rs1_reg;
    logic [4:0]         s1_rs2_reg;
    logic [6:0]         s1_funct7_reg;
    logic [31:0]        s1_imm_reg;

    // Stage 2 state.
    logic               s2_valid_reg;
    logic [31:0]        instr_reg;
    logic               err_reg;
    logic [7:0]         err_count_reg;
    logic [7:0]         err_count_next;

    // Combinational assembly from the S1 registers.
    logic [31:0]        fmt_word   [NUM_FMT];
    logic [31:0]        fmt_masked [NUM_FMT];
    logic [NUM_FMT-1:0] imm_bad_fmt;
    logic [31:0]        word_any;
    logic [31:0]        s1_word;
    logic               sel_one_hot;
    logic               imm_bad;
    logic               s1_err;

    // Handshake: S2 accepts when empty or draining; S1 when empty or moving on.
    logic s2_load;
    logic s1_load;
    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    // Stage 1 register: capture the field bundle whenever S1 is free to load.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sel_reg    <= sel_in;
                s1_opcode_reg <= opcode;
                s1_rd_reg     <= rd;
                s1_funct3_reg <= funct3;
                s1_rs1_reg    <= rs1;
                s1_rs2_reg    <= rs2;
                s1_funct7_reg <= funct7;
                s1_imm_reg    <= imm;
            end
        end
    end

    // Bit layouts of the six RV32I formats.
    assign fmt_word[FMT_R] = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                              s1_rd_reg, s1_opcode_reg};
    assign fmt_word[FMT_I] = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                              s1_rd_reg, s1_opcode_reg};
    assign fmt_word[FMT_S] = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                              s1_imm_reg[4:0], s1_opcode_reg};
    assign fmt_word[FMT_B] = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg,
                              s1_funct3_reg, s1_imm_reg[4:1], s1_imm_reg[11], s1_opcode_reg};
    assign fmt_word[FMT_U] = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
    assign fmt_word[FMT_J] = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                              s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};

    // AND-OR mux: only the selected format contributes when the select is one-hot.
    generate
        for (genvar gi = 0; gi < NUM_FMT; gi++) begin : g_fmt_mask
            assign fmt_masked[gi] = fmt_word[gi] & {32{s1_sel_reg[gi]}};
        end
    endgenerate

    // Combine the masked format words.
    always_comb begin
        word_any = '0;
        for (int k = 0; k < NUM_FMT; k++) begin
            word_any = word_any | fmt_masked[k];
        end
    end

`ifdef ENC_IMM_CHECK_EN
    // Immediate range/alignment checks per format; R has no immediate.
    assign imm_bad_fmt[FMT_R] = 1'b0;
    assign imm_bad_fmt[FMT_I] = s1_imm_reg[31:11] != {21{s1_imm_reg[11]}};
    assign imm_bad_fmt[FMT_S] = s1_imm_reg[31:11] != {21{s1_imm_reg[11]}};
    assign imm_bad_fmt[FMT_B] = (s1_imm_reg[31:12] != {20{s1_imm_reg[12]}}) || s1_imm_reg[0];
    assign imm_bad_fmt[FMT_U] = |s1_imm_reg[11:0];
    assign imm_bad_fmt[FMT_J] = (s1_imm_reg[31:20] != {12{s1_imm_reg[20]}}) || s1_imm_reg[0];
`else
    // Immediate bits outside the selected format are simply dropped.
    assign imm_bad_fmt = '0;
`endif

    assign imm_bad     = |(imm_bad_fmt & s1_sel_reg);
    assign sel_one_hot = (s1_sel_reg != '0) && ((s1_sel_reg & (s1_sel_reg - 6'd1)) == '0);
    assign s1_err      = !sel_one_hot || (s1_opcode_reg[1:0] != 2'b11) || imm_bad;
    assign s1_word     = s1_err ? NOP_WORD : word_any;

    // Stage 2 register: take the assembled word when S2 is empty or being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            instr_reg    <= '0;
            err_reg      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                instr_reg <= s1_word;
                err_reg   <= s1_err;
            end
        end
    end

    // Error counter steps on each handed-off illegal word and sticks at all-ones.
    always_comb begin
        err_count_next = err_count_reg;
        if (s2_valid_reg && out_ready && err_reg && (err_count_reg != 8'hFF)) begin
            err_count_next = err_count_reg + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg <= '0;
        end else begin
            err_count_reg <= err_count_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign instr     = instr_reg;
    assign err       = err_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_instruction_encode.sv
// tb_instruction_encode: table-driven vectors fed through a scoreboard queue,
// plus hand sequences for latency, back-to-back, stall, errors and reset.
// Define ENC_IMM_CHECK_EN for both files to exercise the immediate checks.
`timescale 1ns/1ps

module tb_instruction_encode;

    typedef struct {
        logic [5:0]  sel;      // {J,U,B,S,I,R}
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    localparam int NV = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  fsel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_count;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    exp_t        sb[$];
    int          pop_cyc[$];
    logic [7:0]  model_cnt = 8'd0;
    bit          bp_en = 1'b0;
    exp_t        mon_e;
    vec_t        tbl [NV];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    instruction_encode dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .is_r_instr (fsel[0]),
        .is_i_instr (fsel[1]),
        .is_s_instr (fsel[2]),
        .is_b_instr (fsel[3]),
        .is_u_instr (fsel[4]),
        .is_j_instr (fsel[5]),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct7     (funct7),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .err        (err),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference encoder written with shifts and signed ranges.
    function automatic logic [32:0] ref_enc(input vec_t v);
        logic [31:0] w;
        bit          bad;
        int          s;
        s   = v.imm;
        w   = 32'h0;
        bad = ($countones(v.sel) != 1) || (v.opcode[1:0] != 2'b11);
        case (v.sel)
            6'b000001: w = (32'(v.funct7) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15)
                         | (32'(v.funct3) << 12) | (32'(v.rd) << 7) | 32'(v.opcode);
            6'b000010: w = ((v.imm & 32'hFFF) << 20) | (32'(v.rs1) << 15)
                         | (32'(v.funct3) << 12) | (32'(v.rd) << 7) | 32'(v.opcode);
            6'b000100: w = (((v.imm >> 5) & 32'h7F) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15)
                         | (32'(v.funct3) << 12) | ((v.imm & 32'h1F) << 7) | 32'(v.opcode);
            6'b001000: w = (((v.imm >> 12) & 32'h1) << 31) | (((v.imm >> 5) & 32'h3F) << 25)
                         | (32'(v.rs2) << 20) | (32'(v.rs1) << 15) | (32'(v.funct3) << 12)
                         | (((v.imm >> 1) & 32'hF) << 8) | (((v.imm >> 11) & 32'h1) << 7)
                         | 32'(v.opcode);
            6'b010000: w = (v.imm & 32'hFFFFF000) | (32'(v.rd) << 7) | 32'(v.opcode);
            6'b100000: w = (((v.imm >> 20) & 32'h1) << 31) | (((v.imm >> 1) & 32'h3FF) << 21)
                         | (((v.imm >> 11) & 32'h1) << 20) | (((v.imm >> 12) & 32'hFF) << 12)
                         | (32'(v.rd) << 7) | 32'(v.opcode);
            default:   w = 32'h0;
        endcase
`ifdef ENC_IMM_CHECK_EN
        case (v.sel)
            6'b000010, 6'b000100: if (s < -2048 || s > 2047) bad = 1'b1;
            6'b001000: if (s < -4096 || s > 4095 || (v.imm & 32'h1) != 0) bad = 1'b1;
            6'b010000: if ((v.imm & 32'hFFF) != 0) bad = 1'b1;
            6'b100000: if (s < -1048576 || s > 1048575 || (v.imm & 32'h1) != 0) bad = 1'b1;
            default: ;
        endcase
`else
        s = s;
`endif
        if (bad) return {1'b1, 32'h0000_0013};
        return {1'b0, w};
    endfunction

    function automatic vec_t mk(input logic [5:0] sel, input logic [6:0] op, input logic [4:0] d,
                                input logic [2:0] f3, input logic [4:0] a, input logic [4:0] b,
                                input logic [6:0] f7, input logic [31:0] im,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.sel = sel; v.opcode = op; v.rd = d; v.funct3 = f3; v.rs1 = a; v.rs2 = b;
        v.funct7 = f7; v.imm = im; v.exp_instr = ei; v.exp_err = ee;
        return v;
    endfunction

    function automatic vec_t mk_rand();
        vec_t        v;
        logic [32:0] r;
        v.sel    = 6'(1 << $urandom_range(0, 5));
        if ($urandom_range(0, 7) == 0) v.sel = 6'($urandom);
        v.opcode = {5'($urandom), 2'b11};
        if ($urandom_range(0, 7) == 0) v.opcode = 7'($urandom);
        v.rd     = 5'($urandom);
        v.funct3 = 3'($urandom);
        v.rs1    = 5'($urandom);
        v.rs2    = 5'($urandom);
        v.funct7 = 7'($urandom);
        v.imm    = $urandom;
        if ($urandom_range(0, 1) == 0) v.imm = 32'($signed(12'($urandom))) & 32'hFFFF_FFFE;
        r = ref_enc(v);
        v.exp_instr = r[31:0];
        v.exp_err   = r[32];
        return v;
    endfunction

    // Drive one bundle and hold it until accepted; push the expectation on accept.
    task automatic send(input vec_t v);
        bit   done;
        int   n;
        exp_t e;
        fsel = v.sel; opcode = v.opcode; rd = v.rd; funct3 = v.funct3;
        rs1 = v.rs1; rs2 = v.rs2; funct7 = v.funct7; imm = v.imm;
        in_valid = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                e.instr = v.exp_instr;
                e.err   = v.exp_err;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected accept", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d words still pending, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        model_cnt = 8'd0;
        reset = 1'b0;
    endtask

    // Random backpressure while enabled.
    always @(negedge clk) begin
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: scoreboard pop on each output handshake plus err_count tracking.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            check("err_count", 32'(err_count), 32'(model_cnt));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_out: got out_valid=1 instr=%h, expected no pending word", instr);
                end else begin
                    mon_e = sb.pop_front();
                    check("instr", instr, mon_e.instr);
                    check("err", 32'(err), 32'(mon_e.err));
                    pop_cyc.push_back(cyc);
                    if (mon_e.err && model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   ev;
        logic [31:0] held;

        tbl[0]  = mk(6'b000010, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'd0, 32'd21,        32'h01500093, 1'b0);
        tbl[1]  = mk(6'b000001, 7'h33, 5'd3,  3'd0, 5'd1, 5'd2, 7'd0, 32'd0,         32'h002081B3, 1'b0);
        tbl[2]  = mk(6'b000100, 7'h23, 5'd0,  3'd2, 5'd1, 5'd2, 7'd0, 32'd1,         32'h0020A0A3, 1'b0);
        tbl[3]  = mk(6'b100000, 7'h6F, 5'd25, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4,         32'h00400CEF, 1'b0);
        tbl[4]  = mk(6'b001000, 7'h63, 5'd0,  3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC,  32'hFE208EE3, 1'b0);
        tbl[5]  = mk(6'b010000, 7'h37, 5'd5,  3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000,  32'h123452B7, 1'b0);
        tbl[6]  = mk(6'b000000, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'd0, 32'd5,         32'h00000013, 1'b1);
        tbl[7]  = mk(6'b000011, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'd0, 32'd21,        32'h00000013, 1'b1);
        tbl[8]  = mk(6'b000010, 7'h10, 5'd1,  3'd0, 5'd0, 5'd0, 7'd0, 32'd21,        32'h00000013, 1'b1);
`ifdef ENC_IMM_CHECK_EN
        tbl[9]  = mk(6'b000010, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'd0, 32'h800,       32'h00000013, 1'b1);
        tbl[10] = mk(6'b001000, 7'h63, 5'd0,  3'd0, 5'd0, 5'd0, 7'd0, 32'd3,         32'h00000013, 1'b1);
`else
        tbl[9]  = mk(6'b000010, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'd0, 32'h800,       32'h80000093, 1'b0);
        tbl[10] = mk(6'b001000, 7'h63, 5'd0,  3'd0, 5'd0, 5'd0, 7'd0, 32'd3,         32'h00000163, 1'b0);
`endif
        for (int i = 11; i < NV; i++) tbl[i] = mk_rand();

        // Reset with a bundle offered; it must be ignored.
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        fsel = 6'b000010; opcode = 7'h13; rd = 5'd1; funct3 = 3'd0;
        rs1 = 5'd0; rs2 = 5'd0; funct7 = 7'd0; imm = 32'd21;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        repeat (2) @(negedge clk);

        // Latency: out_valid appears exactly two cycles after the bundle is offered.
        send(tbl[0]);
        #1;
        check("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
        check("lat_instr", instr, 32'h01500093);
        @(negedge clk);
        drain();

        // Back-to-back ADD, SW, JAL leave on consecutive cycles.
        pop_cyc.delete();
        send(tbl[1]); send(tbl[2]); send(tbl[3]);
        drain();
        check("b2b_count", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3) begin
            check("b2b_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
            check("b2b_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        end

        // Illegal bundles: double select, then bad opcode.
        check("errcnt_start", 32'(err_count), 32'd0);
        send(tbl[7]); drain();
        check("errcnt_after1", 32'(err_count), 32'd1);
        send(tbl[8]); drain();
        check("errcnt_after2", 32'(err_count), 32'd2);

        // Stall: two accepted, the rest wait; output holds; order preserved.
        out_ready = 1'b0;
        send(tbl[4]);
        send(tbl[5]);
        fsel = tbl[1].sel; opcode = tbl[1].opcode; rd = tbl[1].rd; funct3 = tbl[1].funct3;
        rs1 = tbl[1].rs1; rs2 = tbl[1].rs2; funct7 = tbl[1].funct7; imm = tbl[1].imm;
        in_valid = 1'b1;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        held = instr;
        check("stall_head", held, 32'hFE208EE3);
        @(negedge clk);
        #1;
        check("stall_in_ready2", 32'(in_ready), 32'd0);
        check("stall_hold", instr, held);
        @(negedge clk);
        out_ready = 1'b1;
        send(tbl[1]);
        send(tbl[2]);
        drain();

        // Full table under random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(tbl[i]);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        bp_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Saturation of the error counter.
        ev = mk(6'b000000, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
        for (int i = 0; i < 260; i++) send(ev);
        drain();
        check("errcnt_saturated", 32'(err_count), 32'hFF);

        // Reset with both stages full and err_count at 5.
        do_reset();
        for (int i = 0; i < 5; i++) send(ev);
        drain();
        check("errcnt_five", 32'(err_count), 32'd5);
        out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        reset = 1'b1;
        fsel = tbl[2].sel; opcode = tbl[2].opcode; rd = tbl[2].rd; funct3 = tbl[2].funct3;
        rs1 = tbl[2].rs1; rs2 = tbl[2].rs2; funct7 = tbl[2].funct7; imm = tbl[2].imm;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        model_cnt = 8'd0;
        #1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_err_count", 32'(err_count), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rst2_discard", 32'(out_valid), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
